seq_divider: RTL and testbench

8-bit unsigned sequential restoring divider, the inverse of the team's 8-bit ripple-carry adder and multiplier datapaths in the arithmetic lab set. It computes quotient and remainder by repeated shift-and-subtract, one quotient bit per clock, so an operation takes 8 cycles. A start/ready/done handshake lets a controller or testbench issue operations back-to-back.

---
 rtl/seq_divider.sv | 110 +++++++++++
 tb/tb_seq_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// 8-bit unsigned restoring divider: one quotient bit per clock, start/ready/done handshake.
// Q, R and DZ are registered and change only on entry to DONE or on reset.
module seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       DZ,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Handshake: start is honoured only on a rising edge where ready is high
    // (state IDLE). A and B are captured on that same edge and never sampled
    // again. done is a single-cycle pulse, and Q/R/DZ are valid from that
    // cycle until the next result is loaded. ready, busy and done are
    // mutually exclusive.

    logic [1:0] state;
    logic [7:0] w;
    logic [7:0] d;
    logic [7:0] p;
    logic [2:0] count;
    logic       dz_pend;

    logic [8:0] t;
    logic       no_borrow;
    logic [7:0] diff;
    logic [7:0] p_next;
    logic [7:0] w_next;

    // The partial remainder is stored in 8 bits. After each step it is either
    // diff (< D) or a restored T (<= D), so the ninth bit of P is always zero.
    always_comb begin
        t         = {p, w[7]};
        no_borrow = (t >= {1'b0, d});
        diff      = t[7:0] + ~d + 8'd1;
        p_next    = no_borrow ? diff : t[7:0];
        w_next    = {w[6:0], no_borrow};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            w       <= 8'd0;
            d       <= 8'd0;
            p       <= 8'd0;
            count   <= 3'd0;
            dz_pend <= 1'b0;
            Q       <= 8'd0;
            R       <= 8'd0;
            DZ      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // A zero divisor spends one RUN cycle so that done
                        // arrives one cycle after the accepting edge.
                        w       <= A;
                        d       <= B;
                        p       <= 8'd0;
                        count   <= 3'd0;
                        dz_pend <= (B == 8'd0);
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (dz_pend) begin
                        Q       <= 8'hFF;
                        R       <= w;
                        DZ      <= 1'b1;
                        dz_pend <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        p     <= p_next;
                        w     <= w_next;
                        count <= count + 3'd1;
                        if (count == 3'd7) begin
                            Q     <= w_next;
                            R     <= p_next;
                            DZ    <= 1'b0;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset, edge operands, divide-by-zero,
// back-to-back operation, mid-run reset and a broad dividend/divisor sweep.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic [1:0] dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] prev_q  = 8'd0;
    logic [7:0] prev_r  = 8'd0;
    logic       prev_dz = 1'b0;

    logic [7:0] av [30];
    logic [7:0] bv [30];
    logic [7:0] sweep_b [6];

    seq_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (a),
        .B         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .Q         (q),
        .R         (r),
        .DZ        (dz),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE; A/B and start are scrambled while it runs.
    task automatic do_div(input logic [7:0] av_i, input logic [7:0] bv_i,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input int elat);
        int   n;
        logic got;
        check("ready_before_start", 32'(ready), 32'd1);
        start = 1'b1;
        a     = av_i;
        b     = bv_i;
        step();
        check("busy_after_accept", 32'(busy), 32'd1);
        check("ready_after_accept", 32'(ready), 32'd0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            start = 1'($urandom_range(0, 1));
            a     = 8'($urandom);
            b     = 8'($urandom);
            step();
            n++;
            if (done) begin
                got = 1'b1;
            end else begin
                check("q_hold_in_run", 32'(q), 32'(prev_q));
                check("r_hold_in_run", 32'(r), 32'(prev_r));
                check("dz_hold_in_run", 32'(dz), 32'(prev_dz));
            end
        end
        check("latency", 32'(n), 32'(elat));
        check("q_result", 32'(q), 32'(eq));
        check("r_result", 32'(r), 32'(er));
        check("dz_result", 32'(dz), 32'(edz));
        prev_q  = eq;
        prev_r  = er;
        prev_dz = edz;
        start = 1'b0;
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after_done", 32'(ready), 32'd1);
        check("q_hold_after_done", 32'(q), 32'(prev_q));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        step();
        step();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_dz", 32'(dz), 32'd0);
        rst_n = 1'b1;
        step();

        do_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8);
        do_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
        do_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
        do_div(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 8);
        do_div(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1);
        do_div(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 8);
        do_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);
        do_div(8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 8);
        do_div(8'd255, 8'd128, 8'd1, 8'd127, 1'b0, 8);

        // Back-to-back: start high at every acceptance edge (spaced 10 apart),
        // held high for two operations, then toggled randomly outside IDLE.
        for (int j = 0; j < 30; j++) begin
            int m;
            start = (j < 20 || j % 10 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            av[j] = 8'($urandom);
            bv[j] = 8'($urandom_range(1, 255));
            a     = av[j];
            b     = bv[j];
            step();
            m = j % 10;
            check("b2b_busy", 32'(busy), 32'(m <= 7));
            check("b2b_done", 32'(done), 32'(m == 8));
            check("b2b_ready", 32'(ready), 32'(m == 9));
            if (m == 8) begin
                prev_q  = av[j-8] / bv[j-8];
                prev_r  = av[j-8] % bv[j-8];
                prev_dz = 1'b0;
            end
            check("b2b_q", 32'(q), 32'(prev_q));
            check("b2b_r", 32'(r), 32'(prev_r));
            check("b2b_dz", 32'(dz), 32'(prev_dz));
        end
        start = 1'b0;

        // Reset asserted for the edge that would perform iteration 4 of 100/3.
        start = 1'b1;
        a     = 8'd100;
        b     = 8'd3;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_q", 32'(q), 32'd0);
        check("midrst_r", 32'(r), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        prev_q  = 8'd0;
        prev_r  = 8'd0;
        prev_dz = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("midrst_no_done", 32'(done), 32'd0);
        end
        do_div(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 8);

        // Every dividend against a spread of divisors, checked against the
        // division model and the A = Q*B + R, R < B invariants.
        sweep_b[0] = 8'd1;
        sweep_b[1] = 8'd2;
        sweep_b[2] = 8'd7;
        sweep_b[3] = 8'd128;
        sweep_b[4] = 8'd255;
        for (int ai = 0; ai < 256; ai++) begin
            sweep_b[5] = 8'($urandom_range(1, 255));
            for (int bi = 0; bi < 6; bi++) begin
                logic [7:0] sa;
                logic [7:0] sb;
                sa = 8'(ai);
                sb = sweep_b[bi];
                do_div(sa, sb, sa / sb, sa % sb, 1'b0, 8);
                check("inv_sum", 32'(q) * 32'(sb) + 32'(r), 32'(sa));
                check("inv_r_lt_b", 32'(r < sb), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
